// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave exposing a 16x8 register file through a 2-byte command/data protocol.
// Define SPI_SLAVE_AUTOINC_EN to allow multi-byte bursts with address auto-increment.
module spi_slave_regs #(
    parameter int         NREGS     = 16,
    parameter logic [7:0] RESET_VAL = 8'h00,
    parameter logic [7:0] SIG_BYTE  = 8'hA5,
    localparam int        AW        = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sclk,
    input  logic          cs,
    input  logic          mosi,
    output logic          miso,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          frame_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Input synchronisers: [0],[1] form the 2-flop synchroniser, [2] is the edge-detect history.
    logic [2:0] sclk_sr, cs_sr;
    logic [1:0] mosi_sr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_sr <= '0;
            cs_sr   <= '0;
            mosi_sr <= '0;
        end else begin
            sclk_sr <= {sclk_sr[1:0], sclk};
            cs_sr   <= {cs_sr[1:0], cs};
            mosi_sr <= {mosi_sr[0], mosi};
        end
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign cs_rise   = cs_sr[1] & ~cs_sr[2];
    assign cs_fall   = ~cs_sr[1] & cs_sr[2];
    assign mosi_s    = mosi_sr[1];

    logic [7:0]    regs [NREGS];
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_sh;
    logic [7:0]    tx_sh;
    logic [7:0]    rd_latch;
    logic [AW-1:0] addr_q;
    logic          is_read;

    logic          active;
    logic          bit_event;
    logic          byte_end;
    logic [7:0]    rx_byte;

    // cs rising wins over a coincident sclk rise, so that bit never reaches the shifter.
    assign active    = (state_q != IDLE);
    assign bit_event = sclk_rise & active & ~cs_rise;
    assign byte_end  = bit_event & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sh[6:0], mosi_s};

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_d = CMD;
                CMD:  if (byte_end) state_d = DATA;
`ifdef SPI_SLAVE_AUTOINC_EN
                DATA: state_d = DATA;
`else
                DATA: if (byte_end) state_d = DONE;
`endif
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: decoded per-cycle actions
    logic          cmd_end;
    logic          data_end;
    logic          do_write;
    logic          frame_abort;
    logic          frame_start;
    logic          tx_step;
    logic [7:0]    next_tx;
    logic [AW-1:0] next_addr;

    always_comb begin
        cmd_end     = 1'b0;
        data_end    = 1'b0;
        do_write    = 1'b0;
        frame_abort = 1'b0;
        frame_start = 1'b0;
        tx_step     = 1'b0;
        next_tx     = 8'h00;
        next_addr   = AW'(addr_q + 1'b1);
        if (cs_rise) begin
            frame_abort = active && (bit_cnt != 3'd0);
        end else begin
            frame_start = (state_q == IDLE) && cs_fall;
            tx_step     = active && sclk_fall;
            cmd_end     = (state_q == CMD) && byte_end;
            data_end    = (state_q == DATA) && byte_end;
            do_write    = data_end && !is_read;
        end
        // Only a read in the data phase returns register content; every other byte is zero.
        if (state_q == DATA && is_read) begin
            next_tx = rd_latch;
        end
    end

    // Bit counter, receive shifter and command capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            rx_sh    <= 8'h00;
            addr_q   <= '0;
            is_read  <= 1'b0;
            rd_latch <= 8'h00;
        end else begin
            if (frame_start || cs_rise) begin
                bit_cnt <= 3'd0;
            end else if (bit_event) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sh   <= rx_byte;
            end

            if (cmd_end) begin
                addr_q   <= rx_byte[AW-1:0];
                is_read  <= rx_byte[7];
                rd_latch <= regs[rx_byte[AW-1:0]];
            end
`ifdef SPI_SLAVE_AUTOINC_EN
            else if (data_end) begin
                addr_q <= next_addr;
                if (is_read) begin
                    rd_latch <= regs[next_addr];
                end
            end
`endif
        end
    end

    // Transmit shifter: a new byte is loaded on the first fall after a byte boundary.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_sh <= 8'h00;
            miso  <= 1'b0;
        end else begin
            if (frame_start) begin
                tx_sh <= SIG_BYTE;
            end else if (tx_step) begin
                if (bit_cnt == 3'd0) begin
                    tx_sh <= next_tx;
                end else begin
                    tx_sh <= {tx_sh[6:0], 1'b0};
                end
            end
            miso <= active ? tx_sh[7] : 1'b0;
        end
    end

    // Register file and write-commit strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            wr_valid  <= do_write;
            frame_err <= frame_abort;
            if (do_write) begin
                regs[addr_q] <= rx_byte;
                wr_addr      <= addr_q;
                wr_data      <= rx_byte;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: SPI frames driven bit by bit, miso bytes and
// write strobes checked against expected queues.
module tb_spi_slave_regs;

    localparam int HALF = 6;

    logic       clock;
    logic       reset;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;

    spi_slave_regs dut (
        .clock     (clock),
        .reset     (reset),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_q[$];
    logic [11:0] exp_wr_q[$];
    int          exp_wr_total = 0;
    int          exp_ferr = 0;
    int          wr_count = 0;
    int          ferr_count = 0;
    logic [7:0]  model [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe cycle is counted and matched against the expected queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (wr_valid) begin
                wr_count++;
                if (exp_wr_q.size() > 0) begin
                    check("wr_addr_data", {20'h0, wr_addr, wr_data}, {20'h0, exp_wr_q.pop_front()});
                end
            end
            if (frame_err) ferr_count++;
        end
    end

    // driver tasks
    task automatic xfer_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nb; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clock);
            rx[7-i] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clock);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input int n, input logic [31:0] bytes, input int abort_bits);
        logic [7:0] tx;
        logic [7:0] rx;
        cs = 1'b0;
        repeat (HALF) @(negedge clock);
        for (int b = 0; b < n; b++) begin
            tx = bytes[31-8*b -: 8];
            xfer_bits(tx, 8, rx);
            if (exp_q.size() > 0) check($sformatf("miso_byte%0d", b), {24'h0, rx}, {24'h0, exp_q.pop_front()});
            else check("miso_queue_empty", {24'h0, rx}, 32'hxxxx_xxxx);
        end
        if (abort_bits > 0) xfer_bits(8'h99, abort_bits, rx);
        repeat (HALF) @(negedge clock);
        cs = 1'b1;
        repeat (4*HALF) @(negedge clock);
        check("wr_count", wr_count, exp_wr_total);
        check("frame_err_count", ferr_count, exp_ferr);
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        exp_wr_q.push_back({a, d});
        exp_wr_total++;
        model[a] = d;
        spi_frame(2, {4'h0, a, d, 16'h0}, 0);
    endtask

    task automatic reg_read(input logic [3:0] a);
        exp_q.push_back(8'hA5);
        exp_q.push_back(model[a]);
        spi_frame(2, {4'h8, a, 8'h00, 16'h0}, 0);
    endtask

    initial begin
        logic [7:0] rx;
        logic [3:0] ra;
        logic [7:0] rd;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        reset = 1'b1;
        sclk  = 1'b0;
        cs    = 1'b1;
        mosi  = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_miso", {31'h0, miso}, 32'h0);
        check("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
        check("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
        check("rst_wr_data", {24'h0, wr_data}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        reset = 1'b0;
        repeat (4*HALF) @(negedge clock);

        // reset value readback, then basic write and readback
        reg_read(4'hF);
        reg_write(4'h3, 8'h5C);
        reg_read(4'h3);

        // reset in the middle of the data byte of a write
        cs = 1'b0;
        repeat (HALF) @(negedge clock);
        xfer_bits(8'h05, 8, rx);
        xfer_bits(8'h77, 4, rx);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (3) @(negedge clock);
        check("midrst_miso", {31'h0, miso}, 32'h0);
        check("midrst_wr_valid", {31'h0, wr_valid}, 32'h0);
        reset = 1'b0;
        repeat (2*HALF) @(negedge clock);
        cs = 1'b1;
        repeat (4*HALF) @(negedge clock);
        check("midrst_no_write", wr_count, exp_wr_total);
        check("midrst_no_ferr", ferr_count, exp_ferr);
        reg_read(4'h5);
        reg_read(4'h3);

        // abort after 4 bits of the data byte
        reg_write(4'h7, 8'h3C);
        exp_q.push_back(8'hA5);
        exp_ferr++;
        spi_frame(1, {8'h07, 24'h0}, 4);
        reg_read(4'h7);

        // three-byte write frame
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_wr_q.push_back({4'hF, 8'h11});
        exp_wr_total++;
        model[15] = 8'h11;
`ifdef SPI_SLAVE_AUTOINC_EN
        exp_wr_q.push_back({4'h0, 8'h22});
        exp_wr_total++;
        model[0] = 8'h22;
`endif
        spi_frame(3, {8'h0F, 8'h11, 8'h22, 8'h00}, 0);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h11);
`ifdef SPI_SLAVE_AUTOINC_EN
        exp_q.push_back(8'h22);
`else
        exp_q.push_back(8'h00);
`endif
        spi_frame(3, {8'h8F, 8'h00, 8'h00, 8'h00}, 0);
        reg_read(4'h0);

        // random write/readback pairs away from the burst addresses
        for (int k = 0; k < 4; k++) begin
            ra = 4'($urandom_range(1, 14));
            rd = 8'($urandom_range(0, 255));
            reg_write(ra, rd);
            reg_read(ra);
        end

        check("exp_q_drained", exp_q.size(), 0);
        check("exp_wr_q_drained", exp_wr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
